// File: rtl/pcm_sample_mixer_pkg.sv
// Shared types and helpers for the PCM sample mixer and its tick source.
package pcm_mix_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] PCM_MID = 8'h80;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  // Attenuate the accumulated sum, then clamp to the 8-bit PCM range.
  function automatic logic [SAMPLE_W-1:0] sat8(input logic [11:0] acc, input logic [1:0] shift);
    logic [11:0] s;
    s = acc >> shift;
    return (s > 12'd255) ? 8'hFF : s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/pcm_sample_mixer_if.sv
// Per-channel sample handshake from the bytebeat generators into the mixer.
interface pcm_sample_mixer_if
  import pcm_mix_pkg::*;
#(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_data;
  logic [NUM_CH-1:0]               ch_vld;
  logic [NUM_CH-1:0]               ch_rdy;

  modport master (output ch_data, ch_vld, input ch_rdy);
  modport slave  (input ch_data, ch_vld, output ch_rdy);
endinterface

// File: rtl/pcm_sample_tick.sv
// Free-running clock-enable divider: one tick every DIV clk cycles.
module pcm_sample_tick #(
  parameter int DIV = 512
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    tick      = (div_cnt_q == CW'(DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/pcm_sample_mixer.sv
// Captures one sample per channel each sample period, sums the masked channels
// one per cycle, and emits a scaled, saturated 8-bit sample with a strobe.
module pcm_sample_mixer
  import pcm_mix_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DIV    = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  pcm_sample_mixer_if.slave    bus,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [1:0]           shift,
  output logic [SAMPLE_W-1:0]  sample_out,
  output logic                 sample_strobe,
  output logic [7:0]           underrun_cnt
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = SAMPLE_W + $clog2(NUM_CH);

  // The scan must finish before the next tick, so the period has to cover it.
  if (DIV < NUM_CH + 3) begin : g_div_chk
    $error("pcm_sample_mixer: DIV must be >= NUM_CH+3");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_chk
    $error("pcm_sample_mixer: NUM_CH must be in 1..16");
  end

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [AW-1:0]                   acc_q, acc_d;
  logic [NUM_CH-1:0]               full_q, full_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] last_q, last_d;
  logic [SAMPLE_W-1:0]             sample_out_q, sample_out_d;
  logic                            strobe_q, strobe_d;
  logic [7:0]                      underrun_q, underrun_d;
  logic [NUM_CH-1:0]               take, scan;
  logic                            tick;

  pcm_sample_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  assign bus.ch_rdy = ~full_q;
  assign take       = bus.ch_vld & ~full_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    last_d       = last_q;
    underrun_d   = underrun_q;
    sample_out_d = sample_out_q;
    strobe_d     = 1'b0;
    scan         = '0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        scan[idx_q] = 1'b1;
        if (ch_mask[idx_q]) begin
          if (full_q[idx_q]) begin
            acc_d         = acc_q + AW'(hold_q[idx_q]);
            last_d[idx_q] = hold_q[idx_q];
          end else begin
            // Starved channel repeats its previous sample instead of dropping to zero.
            acc_d = acc_q + AW'(last_q[idx_q]);
            if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
          end
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_CH - 1)) state_d = DONE;
      end
      DONE: begin
        sample_out_d = sat8(12'(acc_q), shift);
        strobe_d     = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh capture on the channel being scanned survives into the next period.
  always_comb begin
    full_d = (full_q & ~scan) | take;
    hold_d = hold_q;
    for (int i = 0; i < NUM_CH; i++)
      if (take[i]) hold_d[i] = bus.ch_data[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      full_q       <= '0;
      hold_q       <= '0;
      last_q       <= {NUM_CH{PCM_MID}};
      sample_out_q <= PCM_MID;
      strobe_q     <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      full_q       <= full_d;
      hold_q       <= hold_d;
      last_q       <= last_d;
      sample_out_q <= sample_out_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sample_out    = sample_out_q;
  assign sample_strobe = strobe_q;
  assign underrun_cnt  = underrun_q;
endmodule

// File: tb/tb_pcm_sample_mixer.sv
// Directed bench for pcm_sample_mixer with NUM_CH=8, DIV=16.
module tb_pcm_sample_mixer;
  localparam int NUM_CH = 8;
  localparam int DIV    = 16;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] ch_mask;
  logic [1:0]        shift;
  logic [7:0]        sample_out;
  logic              sample_strobe;
  logic [7:0]        underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;   // bench's own divider model: equals div_cnt after each edge

  pcm_sample_mixer_if #(.NUM_CH(NUM_CH)) bus ();

  pcm_sample_mixer #(.NUM_CH(NUM_CH), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ch_mask(ch_mask), .shift(shift),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : (cyc + 1) % DIV;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample on the channels in vld for a single cycle.
  task automatic load(input logic [NUM_CH-1:0] vld, input logic [7:0] d0, input logic [7:0] drest);
    bus.ch_vld = vld;
    for (int i = 0; i < NUM_CH; i++) bus.ch_data[i] = (i == 0) ? d0 : drest;
    step();
    bus.ch_vld = '0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (cyc != p && n < 40) begin step(); n++; end
    chk("phase_reach", 32'(cyc), 32'(p));
  endtask

  // Strobe must land 10 cycles after the tick (phase 9) and last one cycle.
  task automatic wait_strobe(input string tag, input logic [7:0] exp_out, input logic [7:0] exp_ur);
    int n = 0;
    while (sample_strobe !== 1'b1 && n < 40) begin step(); n++; end
    chk({tag, "_seen"}, 32'(sample_strobe), 32'd1);
    chk({tag, "_out"}, 32'(sample_out), 32'(exp_out));
    chk({tag, "_phase"}, 32'(cyc), 32'd9);
    chk({tag, "_ur"}, 32'(underrun_cnt), 32'(exp_ur));
    step();
    chk({tag, "_pulse"}, 32'(sample_strobe), 32'd0);
  endtask

  initial begin
    int nstb;
    reset       = 1'b1;
    ch_mask     = 8'hFF;
    shift       = 2'd0;
    bus.ch_vld  = '0;
    bus.ch_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state, then an all-empty period repeats mid-level on 8 channels
    chk("rst_out", 32'(sample_out), 32'h80);
    chk("rst_rdy", 32'(bus.ch_rdy), 32'hFF);
    chk("rst_stb", 32'(sample_strobe), 32'd0);
    chk("rst_ur", 32'(underrun_cnt), 32'd0);
    wait_strobe("s1", 8'hFF, 8'd8);

    // 2: all channels 0x10; ch0 offers 0x20 early and must stall until its scan
    load(8'hFF, 8'h10, 8'h10);
    chk("s2_rdy_full", 32'(bus.ch_rdy), 32'h00);
    bus.ch_vld     = 8'h01;
    bus.ch_data[0] = 8'h20;
    step();
    chk("s2_stall", 32'(bus.ch_rdy), 32'h00);
    nstb = 0;
    while (bus.ch_rdy[0] !== 1'b1 && nstb < 40) begin step(); nstb++; end
    chk("s2_rdy_after_scan0", 32'(bus.ch_rdy), 32'h01);
    chk("s2_scan0_phase", 32'(cyc), 32'd1);
    step();
    bus.ch_vld = '0;
    chk("s2_recapture", 32'(bus.ch_rdy), 32'h02);
    wait_strobe("s2", 8'h80, 8'd8);
    chk("s2_rdy_kept", 32'(bus.ch_rdy), 32'hFE);

    // 4: only ch0 supplies 0x20; the rest repeat their last 0x10
    wait_strobe("s4", 8'h90, 8'd15);
    chk("s4_rdy", 32'(bus.ch_rdy), 32'hFF);

    // 3: saturation and attenuation
    load(8'hFF, 8'hFF, 8'hFF);
    chk("s3a_rdy", 32'(bus.ch_rdy), 32'h00);
    wait_strobe("s3a", 8'hFF, 8'd15);
    shift = 2'd3;
    load(8'hFF, 8'hFF, 8'hFF);
    wait_strobe("s3b", 8'hFF, 8'd15);
    load(8'hFF, 8'h80, 8'h80);
    wait_strobe("s3c", 8'h80, 8'd15);

    // 5: only ch0 in the mix; others are drained without counting underrun
    shift   = 2'd0;
    ch_mask = 8'h01;
    load(8'hFF, 8'h40, 8'hFF);
    chk("s5_rdy_full", 32'(bus.ch_rdy), 32'h00);
    wait_strobe("s5", 8'h40, 8'd15);
    chk("s5_rdy_drained", 32'(bus.ch_rdy), 32'hFF);

    // 6: reset while scanning channel 4
    ch_mask = 8'hFF;
    load(8'hFF, 8'h11, 8'h22);
    wait_phase(4);
    reset = 1'b1;
    step();
    chk("s6_out", 32'(sample_out), 32'h80);
    chk("s6_rdy", 32'(bus.ch_rdy), 32'hFF);
    chk("s6_stb", 32'(sample_strobe), 32'd0);
    chk("s6_ur", 32'(underrun_cnt), 32'd0);
    chk("s6_div", 32'(dut.u_tick.div_cnt_q), 32'd0);
    reset = 1'b0;
    nstb = 0;
    repeat (20) begin
      step();
      if (sample_strobe === 1'b1) nstb++;
    end
    chk("s6_no_strobe", 32'(nstb), 32'd0);
    wait_strobe("s6_post", 8'hFF, 8'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
